// File: rtl/limb_mult_sequencer_pkg.sv
// Shared definitions for the limb-serial wide multiplier: limb width, FSM
// states and the limb-count-to-operand-width helper.
package limb_mult_sequencer_pkg;

  localparam int LIMB_BITS = 17;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  function automatic int opnd_width(input int num_limbs);
    return LIMB_BITS * num_limbs;
  endfunction

endpackage

// File: rtl/limb_mult_sequencer_mult.sv
// Combinational 17x17 unsigned multiplier; maps onto a single DSP slice once
// the downstream register stages are retimed into it.
module mult_17x17
  import limb_mult_sequencer_pkg::*;
(
  input  logic [LIMB_BITS-1:0]   a,
  input  logic [LIMB_BITS-1:0]   b,
  output logic [2*LIMB_BITS-1:0] p
);

  assign p = {{LIMB_BITS{1'b0}}, a} * {{LIMB_BITS{1'b0}}, b};

endmodule

// File: rtl/limb_mult_sequencer.sv
// Wide unsigned multiply on one shared 17x17 multiplier: limb pairs are issued
// one per cycle and the shifted partial products are summed in an accumulator.
module limb_mult_sequencer
  import limb_mult_sequencer_pkg::*;
#(
  parameter  int NUM_LIMBS = 4,
  parameter  int MULT_LAT  = 2,
  localparam int W         = opnd_width(NUM_LIMBS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int PW  = 2 * W;
  localparam int PPW = 2 * LIMB_BITS;
  localparam int CW  = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam int TW  = $clog2(2 * NUM_LIMBS);
  localparam int DW  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_t         state;
  logic [CW-1:0]  i_cnt, j_cnt;
  logic [DW-1:0]  drain_cnt;
  logic [W-1:0]   x_r, y_r;
  logic [PW-1:0]  acc;

  logic [LIMB_BITS-1:0] x_limb, y_limb;
  logic [PPW-1:0]       pp;
  logic [TW-1:0]        tag;
  logic [PW-1:0]        pp_shift;

  logic [MULT_LAT:1] vld_pipe;
  logic [PPW-1:0]    pp_pipe  [1:MULT_LAT];
  logic [TW-1:0]     tag_pipe [1:MULT_LAT];

  assign x_limb = x_r[LIMB_BITS*i_cnt +: LIMB_BITS];
  assign y_limb = y_r[LIMB_BITS*j_cnt +: LIMB_BITS];
  assign tag    = TW'(i_cnt) + TW'(j_cnt);

  mult_17x17 u_mult (
    .a (x_limb),
    .b (y_limb),
    .p (pp)
  );

  // Data stages carry no reset so the DSP output registers can absorb them;
  // only the valid bits decide whether a stage reaches the accumulator.
  always_ff @(posedge clk) begin
    pp_pipe[1]  <= pp;
    tag_pipe[1] <= tag;
    for (int k = 2; k <= MULT_LAT; k++) begin
      pp_pipe[k]  <= pp_pipe[k-1];
      tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign pp_shift = PW'(pp_pipe[MULT_LAT]) << (LIMB_BITS * tag_pipe[MULT_LAT]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc       <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      x_r       <= '0;
      y_r       <= '0;
    end else begin
      vld_pipe[1] <= (state == ISSUE);
      for (int k = 2; k <= MULT_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (vld_pipe[MULT_LAT]) acc <= acc + pp_shift;

      case (state)
        IDLE: if (in_valid) begin
          x_r      <= x;
          y_r      <= y;
          acc      <= '0;
          i_cnt    <= '0;
          j_cnt    <= '0;
          in_ready <= 1'b0;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (j_cnt == CW'(NUM_LIMBS - 1)) begin
            j_cnt <= '0;
            if (i_cnt == CW'(NUM_LIMBS - 1)) begin
              i_cnt     <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              i_cnt <= i_cnt + CW'(1);
            end
          end else begin
            j_cnt <= j_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(MULT_LAT - 1)) begin
            drain_cnt <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p = acc;

endmodule

// File: tb/tb_limb_mult_sequencer.sv
// Runs three parameterisations side by side, each against a plain x*y
// reference with an idle/busy handshake model and the closed-form latency.
module tb_limb_mult_sequencer;
  import limb_mult_sequencer_pkg::*;

  localparam int NCFG = 3;
  localparam logic [511:0] Y_DIR      = 512'hDEAD_BEEF_CAFE_F00D_1;
  localparam logic [511:0] P_ONES_DEF = 512'hFFFF_FFFF_FFFF_FFFF_E000_0000_0000_0000_01;
  localparam logic [511:0] P_ONES_N1  = 512'h3_FFFC_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input int cfg, input logic [511:0] act,
                       input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s got=%0h want=%0h at cycle %0d", cfg, nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int N     = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    localparam int L     = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int W     = opnd_width(N);
    localparam int PW    = 2 * W;
    localparam int LAT   = N * N + L + 1;
    localparam int NDIR  = (g == 0) ? 6 : 1;
    localparam int NRAND = (g == 2) ? 300 : 1000;
    localparam logic [511:0] ONES_P = (512'(1) << PW) - (512'(1) << (W + 1)) + 512'd1;

    logic          reset, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  x, y;
    logic [PW-1:0] p;

    limb_mult_sequencer #(.NUM_LIMBS(N), .MULT_LAT(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
    );

    // Reference: one op in flight; busy from the cycle after accept until
    // the cycle after the output handshake; result is simply x*y.
    bit            busy = 0, prev_ov = 0, post_rst = 0, has_lit = 0, has_lit_next = 0;
    int            acc_cyc = 0;
    logic [PW-1:0] exp_p = '0;
    logic [511:0]  lit = '0, lit_next = '0;

    always @(negedge clk) begin
      if (reset) begin
        busy     = 0;
        prev_ov  = 0;
        post_rst = 1;
      end else begin
        check("in_ready", g, 512'(in_ready), 512'(!busy));
        check("out_valid", g, 512'(out_valid), 512'(busy && (cyc - acc_cyc >= LAT)));
        if (post_rst) check("p_after_reset", g, 512'(p), 512'(0));
        post_rst = 0;
        if (out_valid && busy) begin
          check("p_model", g, 512'(p), 512'(exp_p));
          if (has_lit) check("p_literal", g, 512'(p), lit);
          if (!prev_ov) check("latency", g, 512'(cyc - acc_cyc), 512'(LAT));
        end
        prev_ov = out_valid;
        if (out_valid && out_ready) busy = 0;
        if (in_valid && in_ready) begin
          busy    = 1;
          acc_cyc = cyc;
          exp_p   = PW'(x) * PW'(y);
          has_lit = has_lit_next;
          lit     = lit_next;
        end
      end
    end

    initial begin
      logic [W-1:0] xv, yv;
      int mode, gap, ov_seen;
      bit ok;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < NDIR + NRAND; k++) begin
        xv = '0; yv = '0;
        for (int b = 0; b < W; b += 32) begin
          xv = (xv << 32) | W'($urandom);
          yv = (yv << 32) | W'($urandom);
        end
        if ($urandom % 8 == 0) xv = '1;
        if ($urandom % 8 == 0) yv = '1;
        if ($urandom % 16 == 0) yv = '0;
        mode = 1; has_lit_next = 0; lit_next = '0;
        gap = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 4));
        if (k < NDIR) begin
          gap = 0;
          case (k)
            0: begin
              xv = '1; yv = '1; mode = 0; has_lit_next = 1;
              lit_next = (g == 0) ? P_ONES_DEF : (g == 1) ? P_ONES_N1 : ONES_P;
            end
            1: begin xv = W'(1); yv = W'(Y_DIR); mode = 0; has_lit_next = 1; lit_next = Y_DIR; end
            2: begin
              xv = W'(512'(1) << 17); yv = W'(Y_DIR); mode = 0;
              has_lit_next = 1; lit_next = Y_DIR << 17;
            end
            3: mode = 2;
            4: mode = 3;
            default: begin xv = W'(3); yv = W'(5); mode = 0; has_lit_next = 1; lit_next = 512'd15; end
          endcase
        end

        repeat (gap) begin @(posedge clk); #1; end
        x = xv; y = yv; in_valid = 1'b1;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          if (in_ready) begin ok = 1; break; end
          @(posedge clk); #1;
        end
        if (!ok) begin
          failures++;
          $display("FAIL cfg%0d accept_timeout op=%0d in_ready=%0b want=1", g, k, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; x = W'($urandom); y = W'($urandom);

        if (mode == 3) begin
          repeat (6) begin @(posedge clk); #1; end
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
        end else begin
          ov_seen = 0; ok = 0;
          for (int c = 0; c < 4 * LAT + 400; c++) begin
            case (mode)
              0:       out_ready = 1'b1;
              1:       out_ready = ($urandom % 3 != 0);
              default: out_ready = (ov_seen >= 10);
            endcase
            if (mode != 0) in_valid = ($urandom % 2 == 1);
            @(negedge clk);
            if (out_valid) ov_seen++;
            if (out_valid && out_ready) begin ok = 1; break; end
            @(posedge clk); #1;
          end
          @(posedge clk); #1;
          in_valid = 1'b0; out_ready = 1'b0;
          if (!ok) begin
            failures++;
            $display("FAIL cfg%0d result_timeout op=%0d out_valid=%0b want=1", g, k, out_valid);
          end
        end
      end
      done_cnt++;
    end
  end

  initial begin
    while (done_cnt < NCFG && $time < 5_000_000) #1000;
    if (done_cnt < NCFG) begin
      failures++;
      $display("FAIL global_timeout done=%0d want=%0d", done_cnt, NCFG);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
